cmp_ge_sched: RTL and testbench
===============================

# cmp_ge_sched

Time-shared scheduler for one 8-bit unsigned magnitude comparator (result is 1 when a ≥ b). N requesters each present an (a, b) operand pair with a valid/ready handshake. The block arbitrates round-robin, sequences the single comparator through a three-state FSM, and returns the result with the winner's ID over a backpressured response channel. It sits between requester logic and the shared comparator, so the comparator netlist is instantiated exactly once.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 8: operand width.
- `IDW`, default 2: response ID width, equal to clog2(N).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N: bit i set means requester i has a pending operand pair.
- `req_a`  in  N*W: requester i's a operand in bits `[i*W +: W]`.
- `req_b`  in  N*W: requester i's b operand in bits `[i*W +: W]`.
- `req_ready`  out  N: one-hot grant; requester i's pair is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  1: response held valid.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_ge`  out  1: registered comparator result, a ≥ b unsigned.
- `resp_id`  out  IDW: index of the requester that owns the response.
- `busy`  out  1: FSM is not in IDLE.

## Operation
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - `req_ready` = one-hot of the round-robin winner among `req_valid`. This is combinational from `req_valid` and the pointer, and is 0 when no request is valid.
  - On a grant: latch `req_a`/`req_b` of the winner into the operand registers, latch the winner index into `id_q`, set `ptr <= (winner+1) mod N`, go to EVAL.
  - With no request valid: stay in IDLE, `ptr` unchanged.
- Round-robin search: start at `ptr` and scan upward with wrap. The first set `req_valid` bit wins. Exactly one `req_ready` bit is high per grant.
- EVAL:
  - The comparator sees only the operand registers.
  - `resp_ge <= (a_q >= b_q)`, `resp_id <= id_q`, go to RESP.
  - `req_ready` = 0.
- RESP:
  - `resp_valid` = 1. `resp_ge` and `resp_id` stay stable until the handshake completes.
  - On `resp_ready`: go to IDLE.
  - Otherwise: stay in RESP indefinitely. `req_ready` = 0.
- Arithmetic: the compare is unsigned, with no sign extension. Equal operands give `resp_ge` = 1.
- Requesters must hold `req_valid` and their operands until granted. Operands of non-winners are ignored.
- A requester that deasserts valid before its grant is simply skipped; no error is raised.
- Reset:
  - State → IDLE, `ptr` → 0.
  - Operand registers, `id_q`, `resp_ge`, `resp_id` → 0.
  - `resp_valid`, `busy`, `req_ready` are 0 in the cycle after `rst` is sampled high.
  - Reset mid-transaction discards the in-flight pair with no response.
  - While `rst` is high, `req_ready` is forced to 0.

## Timing
- Grant occurs in cycle t. `resp_valid` is high from cycle t+2.
- Minimum issue interval is 3 cycles: the response is accepted at t+2, IDLE is reached at t+3, and the next grant can happen at t+3.
- No combinational path from `req_a`/`req_b` to any output. No path from `resp_ready` to any output other than the next-state logic.
- `busy` is high in EVAL and RESP, i.e. from t+1 until the cycle after the response handshake.
- Fairness: with all N requesters continuously valid and `resp_ready` tied high, each requester is granted exactly once per N grants.

## Structure
- Shared package `cmp_pkg` holds:
  - the FSM state enum `cmp_state_t` {IDLE, EVAL, RESP};
  - localparams for default N/W;
  - a function `rr_pick(valid, ptr)` returning the winner index plus a found flag.
- One sub-module, `cmp_ge8`: a purely combinational W-bit unsigned a ≥ b comparator with ports `a`, `b`, `a_gtet_b`. It is instantiated once, and is the unit that gate-level ECO edits target.
- The scheduler contains the FSM, the pointer, the operand/result registers and the grant decode.

## Test plan
- Reset behaviour: assert `rst` for 2 cycles while `req_valid`=4'b1111 → `req_ready`=0, `resp_valid`=0, `busy`=0; after release the first grant goes to requester 0.
- Single request: requester 2 with a=8'h80, b=8'h7F, `resp_ready`=1 → `req_ready`=4'b0100 at t; `resp_valid`=1, `resp_ge`=1, `resp_id`=2 at t+2; IDLE at t+3.
- Equality and less-than:
  - a=b=8'hA5 → `resp_ge`=1;
  - a=8'h00, b=8'hFF → `resp_ge`=0;
  - a=8'hFF, b=8'h00 → `resp_ge`=1.
- Round-robin wrap: all four valid, `resp_ready`=1 → grant order 0,1,2,3,0,…; every grant interval is exactly 3 cycles.
- Backpressure: `resp_ready`=0 for 5 cycles during RESP → `resp_ge`/`resp_id` stable, `req_ready`=0 throughout; one cycle after `resp_ready`=1 the next grant occurs.
- Reset mid-operation: assert `rst` in EVAL → no `resp_valid` ever appears for that pair; `ptr`=0 afterwards.

Source files
------------

// File: rtl/cmp_ge_sched_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg: shared definitions for the time-shared a >= b comparator scheduler.
//   cmp_state_t : scheduler FSM states (IDLE / EVAL / RESP)
//   CMP_*       : default requester count / operand width, maximum requesters
//   rr_pick()   : round-robin winner search starting at a pointer, with wrap
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } cmp_state_t;

    localparam int unsigned CMP_N_DEFAULT = 4;
    localparam int unsigned CMP_W_DEFAULT = 8;
    localparam int unsigned CMP_N_MAX     = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Scan valid[] upward from ptr with wrap at n; the first set bit wins.
    // valid is zero-padded to CMP_N_MAX bits by the caller.
    function automatic rr_pick_t rr_pick(input logic [CMP_N_MAX-1:0] valid,
                                         input logic [2:0]           ptr,
                                         input int unsigned          n = CMP_N_DEFAULT);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < CMP_N_MAX; k++) begin
            j = 32'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !r.found && valid[3'(j)]) begin
                r.found = 1'b1;
                r.idx   = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_ge_sched_ge8.sv
// ---------------------------------------------------------------------------
// cmp_ge8: purely combinational W-bit unsigned magnitude comparator.
//   a, b      : unsigned operands
//   a_gtet_b  : 1 when a >= b
// Kept as its own module so gate-level ECO edits have a single target.
// ---------------------------------------------------------------------------
module cmp_ge8 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_gtet_b
);

    always_comb begin
        a_gtet_b = (a >= b);
    end

endmodule

// File: rtl/cmp_ge_sched.sv
// ---------------------------------------------------------------------------
// cmp_ge_sched: round-robin scheduler sharing one cmp_ge8 among N requesters.
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : per-requester pending operand pair
//   req_a, req_b : packed operands, requester i in [i*W +: W]
//   req_ready    : one-hot grant (IDLE only, 0 while rst is high)
//   resp_valid   : response held valid in RESP
//   resp_ready   : consumer accepts response
//   resp_ge      : registered a >= b result
//   resp_id      : index of the requester owning the response
//   busy         : FSM not in IDLE
// ---------------------------------------------------------------------------
module cmp_ge_sched
    import cmp_pkg::*;
#(
    parameter int unsigned N   = CMP_N_DEFAULT,
    parameter int unsigned W   = CMP_W_DEFAULT,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_ge,
    output logic [IDW-1:0] resp_id,
    output logic           busy
);

    cmp_state_t     state;
    cmp_state_t     state_next;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] id_q;
    logic [IDW-1:0] win_idx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   win_a;
    logic [W-1:0]   win_b;
    logic           ge_comb;
    logic           grant;
    rr_pick_t       pick;
    int unsigned    nxt;

    // ---------------- grant decode ----------------
    always_comb begin
        pick    = rr_pick(CMP_N_MAX'(req_valid), 3'(ptr), N);
        win_idx = IDW'(pick.idx);
        grant   = (state == IDLE) && !rst && pick.found;
        win_a   = req_a[32'(pick.idx)*W +: W];
        win_b   = req_b[32'(pick.idx)*W +: W];
        nxt     = 32'(pick.idx) + 1;
        if (nxt >= N) begin
            nxt = 0;
        end
        ptr_next = IDW'(nxt);
    end

    // ---------------- shared comparator (sees operand registers only) -------
    cmp_ge8 #(.W(W)) u_cmp (
        .a        (a_q),
        .b        (b_q),
        .a_gtet_b (ge_comb)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next-state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant) state_next = EVAL;
            EVAL:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_ready[i] = grant && (32'(pick.idx) == i);
        end
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= '0;
            resp_ge <= 1'b0;
            resp_id <= '0;
        end else begin
            if (grant) begin
                a_q  <= win_a;
                b_q  <= win_b;
                id_q <= win_idx;
                ptr  <= ptr_next;
            end
            if (state == EVAL) begin
                resp_ge <= ge_comb;
                resp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_cmp_ge_sched.sv
module tb_cmp_ge_sched;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 8;
    localparam int unsigned IDW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic           resp_ge;
    logic [IDW-1:0] resp_id;
    logic           busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // scoreboard entries: {ge, id}
    logic [2:0] exp_q[$];

    cmp_ge_sched #(.N(N), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ge    (resp_ge),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ops(input int unsigned i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push_exp(input int unsigned id, input logic [7:0] a, input logic [7:0] b);
        logic ge;
        ge = (a >= b);
        exp_q.push_back({ge, 2'(id)});
    endtask

    // advance until a grant appears; returns cycles elapsed (bounded)
    task automatic next_grant(output int unsigned cyc);
        cyc = 0;
        do begin
            step();
            #1;
            cyc++;
        end while (req_ready == '0 && cyc < 20);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            #3;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    // response monitor: pop and compare on each handshake
    always @(negedge clk) begin
        logic [2:0] e;
        #2;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("resp_ge", 32'(resp_ge), 32'(e[2]));
                check("resp_id", 32'(resp_id), 32'(e[1:0]));
            end
        end
    end

    logic [7:0] rr_a [4];
    logic [7:0] rr_b [4];

    initial begin
        int unsigned cyc;
        int unsigned id;

        rr_a[0] = 8'h00; rr_b[0] = 8'hFF;
        rr_a[1] = 8'hFF; rr_b[1] = 8'h00;
        rr_a[2] = 8'hA5; rr_b[2] = 8'hA5;
        rr_a[3] = 8'h80; rr_b[3] = 8'h7F;

        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;
        for (int i = 0; i < 4; i++) set_ops(i, rr_a[i], rr_b[i]);

        // reset held two cycles with all requests valid
        step(); #1;
        check("rst1_req_ready", 32'(req_ready), 0);
        check("rst1_resp_valid", 32'(resp_valid), 0);
        check("rst1_busy", 32'(busy), 0);
        step(); #1;
        check("rst2_req_ready", 32'(req_ready), 0);
        check("rst2_busy", 32'(busy), 0);
        rst = 1'b0;
        #1;
        check("first_grant_oh", 32'(req_ready), 32'h1);
        push_exp(0, rr_a[0], rr_b[0]);

        // round-robin wrap, 3-cycle issue interval
        for (int g = 1; g < 8; g++) begin
            id = g % 4;
            next_grant(cyc);
            check("rr_interval", cyc, 3);
            check("rr_grant_oh", 32'(req_ready), 32'(1) << id);
            push_exp(id, rr_a[id], rr_b[id]);
        end
        step(); #1;
        req_valid = '0;
        check("rr_last_busy", 32'(busy), 1);
        drain();

        // single request from requester 2 (ptr is 0 here)
        step(); #1;
        set_ops(2, 8'h80, 8'h7F);
        req_valid = 4'b0100;
        #1;
        check("single_grant_oh", 32'(req_ready), 32'h4);
        push_exp(2, 8'h80, 8'h7F);
        step(); #1;
        req_valid = '0;
        check("single_t1_busy", 32'(busy), 1);
        check("single_t1_resp_valid", 32'(resp_valid), 0);
        check("single_t1_req_ready", 32'(req_ready), 0);
        step(); #1;
        check("single_t2_resp_valid", 32'(resp_valid), 1);
        check("single_t2_resp_ge", 32'(resp_ge), 1);
        check("single_t2_resp_id", 32'(resp_id), 2);
        step(); #1;
        check("single_t3_idle", 32'(busy), 0);
        drain();

        // backpressure: ptr is 3, requesters 0 and 1 valid -> 0 wins
        step(); #1;
        resp_ready = 1'b0;
        set_ops(0, 8'h33, 8'h33);
        set_ops(1, 8'h01, 8'h02);
        req_valid = 4'b0011;
        #1;
        check("bp_grant_oh", 32'(req_ready), 32'h1);
        push_exp(0, 8'h33, 8'h33);
        step(); #1;
        step(); #1;
        for (int k = 0; k < 5; k++) begin
            check("bp_resp_valid", 32'(resp_valid), 1);
            check("bp_resp_ge", 32'(resp_ge), 1);
            check("bp_resp_id", 32'(resp_id), 0);
            check("bp_req_ready", 32'(req_ready), 0);
            step(); #1;
        end
        resp_ready = 1'b1;
        check("bp_release_req_ready", 32'(req_ready), 0);
        step(); #1;
        check("bp_next_grant_oh", 32'(req_ready), 32'h2);
        push_exp(1, 8'h01, 8'h02);
        step(); #1;
        req_valid = '0;
        drain();

        // reset mid-operation: ptr is 2, requester 1 alone -> grant 1, ptr 2
        step(); #1;
        set_ops(1, 8'hFF, 8'h00);
        req_valid = 4'b0010;
        #1;
        check("mid_grant_oh", 32'(req_ready), 32'h2);
        step(); #1;
        req_valid = '0;
        check("mid_eval_busy", 32'(busy), 1);
        rst = 1'b1;
        step(); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("mid_no_resp_valid", 32'(resp_valid), 0);
            check("mid_not_busy", 32'(busy), 0);
            step(); #1;
        end
        // ptr back at 0: all valid must grant requester 0
        set_ops(0, 8'h00, 8'hFF);
        req_valid = 4'b1111;
        #1;
        check("post_rst_grant_oh", 32'(req_ready), 32'h1);
        push_exp(0, 8'h00, 8'hFF);
        step(); #1;
        req_valid = '0;
        drain();

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
